mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signals shared by mem_arbiter and its environment.
// slave: arbiter side; master: requesters plus memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rsp_valid, if_rdata, d_ack, d_rsp_valid, d_rdata,
        output mem_write, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rsp_valid, if_rdata, d_ack, d_rsp_valid, d_rdata,
        input  mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and sequencer for a single-port memory with registered read data.
// Define MEM_ARB_FIXED_PRIO_EN to give the data port fixed priority instead of round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic              grant;
    logic              grant_data;
    logic              acc_id;     // 0 = fetch, 1 = data
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    assign grant = bus.if_req | bus.d_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign grant_data = bus.d_req;
`else
    logic last_grant;   // id of the most recent winner; reset to data so fetch wins the first tie

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && grant) begin
            last_grant <= grant_data;
        end
    end

    assign grant_data = bus.d_req & (~bus.if_req | ~last_grant);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_id    <= 1'b0;
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant) begin
                acc_id   <= grant_data;
                acc_we   <= grant_data & bus.d_we;
                acc_addr <= grant_data ? bus.d_addr : bus.if_addr;
                if (grant_data) begin
                    acc_wdata <= bus.d_wdata;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port follows the access registers, so address/data hold between accesses.
    assign bus.mem_addr  = acc_addr;
    assign bus.mem_wdata = acc_wdata;
    assign bus.mem_write = (state == ACCESS) & acc_we;

    assign bus.if_ack       = (state == ACCESS) & ~acc_id;
    assign bus.d_ack        = (state == ACCESS) &  acc_id;
    assign bus.if_rsp_valid = (state == RESP)   & ~acc_id;
    assign bus.d_rsp_valid  = (state == RESP)   &  acc_id;
    assign bus.if_rdata     = (state == RESP && !acc_id) ? bus.mem_rdata : '0;
    assign bus.d_rdata      = (state == RESP &&  acc_id) ? bus.mem_rdata : '0;

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 registered-read memory.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    logic busy;
    int   pass_cnt;
    int   total_cnt;

    logic [7:0] mem [256];

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read returns the pre-write contents, one cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic data_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                               input logic chk_rd, input logic [7:0] exp_rd, input string name);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        @(posedge clk); #1;
        total_cnt++;
        if ({bus.d_ack, bus.if_ack, bus.mem_write, bus.mem_addr, busy} !== {1'b1, 1'b0, we, addr, 1'b1})
            $display("FAIL %s_access: d_ack=%b if_ack=%b mem_write=%b mem_addr=%h busy=%b, want 1 0 %b %h 1",
                     name, bus.d_ack, bus.if_ack, bus.mem_write, bus.mem_addr, busy, we, addr);
        else pass_cnt++;
        if (we) begin
            total_cnt++;
            if (bus.mem_wdata !== wdata)
                $display("FAIL %s_wdata: mem_wdata=%h want %h", name, bus.mem_wdata, wdata);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        total_cnt++;
        if ({bus.d_rsp_valid, bus.d_ack, bus.mem_write, bus.if_rsp_valid} !== 4'b1000)
            $display("FAIL %s_resp: rsp/ack/we/if_rsp=%b want 1000", name,
                     {bus.d_rsp_valid, bus.d_ack, bus.mem_write, bus.if_rsp_valid});
        else pass_cnt++;
        if (chk_rd) begin
            total_cnt++;
            if (bus.d_rdata !== exp_rd)
                $display("FAIL %s_rdata: d_rdata=%h want %h", name, bus.d_rdata, exp_rd);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        total_cnt++;
        if ({busy, bus.d_rsp_valid} !== 2'b00)
            $display("FAIL %s_idle: busy=%b d_rsp_valid=%b want 0 0", name, busy, bus.d_rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({bus.if_ack, bus.if_rsp_valid, bus.if_rdata, bus.d_ack, bus.d_rsp_valid, bus.d_rdata,
             bus.mem_write, bus.mem_addr, bus.mem_wdata, busy} !== '0)
            $display("FAIL reset_outputs: outputs nonzero (mem_addr=%h mem_wdata=%h busy=%b) want all 0",
                     bus.mem_addr, bus.mem_wdata, busy);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, bus.if_ack, bus.d_ack, bus.mem_write} !== 4'b0000)
            $display("FAIL reset_idle: busy/if_ack/d_ack/we=%b want 0000",
                     {busy, bus.if_ack, bus.d_ack, bus.mem_write});
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        data_access(1'b1, 8'h3C, 8'hA5, 1'b0, 8'h00, "wr3c");
        data_access(1'b0, 8'h3C, 8'h00, 1'b1, 8'hA5, "rd3c");
    endtask

    task automatic test_fetch();
        data_access(1'b1, 8'h10, 8'h7E, 1'b0, 8'h00, "preload10");
        bus.if_req = 1'b1; bus.if_addr = 8'h10;
        @(posedge clk); #1;
        total_cnt++;
        if ({bus.if_ack, bus.d_ack, bus.mem_write, bus.mem_addr} !== {3'b100, 8'h10})
            $display("FAIL fetch_ack: if_ack/d_ack/we=%b mem_addr=%h want 100 10",
                     {bus.if_ack, bus.d_ack, bus.mem_write}, bus.mem_addr);
        else pass_cnt++;
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        total_cnt++;
        if ({bus.if_rsp_valid, bus.if_ack, bus.d_rsp_valid, bus.d_rdata} !== {3'b100, 8'h00})
            $display("FAIL fetch_rsp: if_rsp/if_ack/d_rsp=%b d_rdata=%h want 100 00",
                     {bus.if_rsp_valid, bus.if_ack, bus.d_rsp_valid}, bus.d_rdata);
        else pass_cnt++;
        total_cnt++;
        if (bus.if_rdata !== 8'h7E)
            $display("FAIL fetch_rdata: if_rdata=%h want 7e", bus.if_rdata);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({busy, bus.if_rsp_valid, bus.if_rdata} !== 10'd0)
            $display("FAIL fetch_idle: busy=%b if_rsp=%b if_rdata=%h want 0 0 00",
                     busy, bus.if_rsp_valid, bus.if_rdata);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [3:0] exp;
        logic       data_win;
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 8'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h3C;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
            data_win = 1'b1;
`else
            data_win = (((k - 1) / 3) % 2) == 1;
`endif
            exp = 4'b0000;
            if (k % 3 == 1) exp = data_win ? 4'b0100 : 4'b1000;
            if (k % 3 == 2) exp = data_win ? 4'b0001 : 4'b0010;
            total_cnt++;
            if ({bus.if_ack, bus.d_ack, bus.if_rsp_valid, bus.d_rsp_valid} !== exp)
                $display("FAIL contention_cyc%0d: if_ack/d_ack/if_rsp/d_rsp=%b want %b", k,
                         {bus.if_ack, bus.d_ack, bus.if_rsp_valid, bus.d_rsp_valid}, exp);
            else pass_cnt++;
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL contention_idle: busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        data_access(1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, "wrff");
        data_access(1'b0, 8'hFF, 8'h00, 1'b1, 8'hFF, "rdff");
        data_access(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "rd00");
    endtask

    task automatic test_midop_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h20; bus.d_wdata = 8'h55;
        @(posedge clk); #1;
        total_cnt++;
        if ({bus.mem_write, bus.mem_addr} !== {1'b1, 8'h20})
            $display("FAIL midop_access: mem_write=%b mem_addr=%h want 1 20", bus.mem_write, bus.mem_addr);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.mem_write, bus.d_ack, busy} !== 3'b000)
            $display("FAIL midop_async: mem_write/d_ack/busy=%b want 000", {bus.mem_write, bus.d_ack, busy});
        else pass_cnt++;
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if ({bus.d_rsp_valid, busy} !== 2'b00)
                $display("FAIL midop_norsp%0d: d_rsp_valid=%b busy=%b want 0 0", k, bus.d_rsp_valid, busy);
            else pass_cnt++;
        end
        data_access(1'b0, 8'h20, 8'h00, 1'b1, 8'h00, "rd20");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_write_read();
        test_fetch();
        test_contention();
        test_boundary();
        test_midop_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end
endmodule
